csi_rx_packet_ctrl: RTL and testbench

CSI_RX_PACKET_CTRL -- requirements
Module: csi_rx_packet_ctrl

---
 rtl/csi_rx_packet_ctrl_pkg.sv | 28 ++
 rtl/csi_rx_packet_ctrl_if.sv | 25 ++
 rtl/csi_wc_counter.sv | 26 ++
 rtl/csi_rx_packet_ctrl.sv | 176 +++++++++++++++++
 tb/tb_csi_rx_packet_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/csi_rx_packet_ctrl_pkg.sv
// CSI-2 receive packet controller: shared types and constants.
// Holds data types, header field widths and FSM states.
package csi_pkg;

    localparam int DT_W  = 6;
    localparam int VC_W  = 2;
    localparam int WC_W  = 16;
    localparam int REM_W = 15;

    localparam logic [DT_W-1:0] DT_FS    = 6'h00;
    localparam logic [DT_W-1:0] DT_FE    = 6'h01;
    localparam logic [DT_W-1:0] DT_RAW10 = 6'h2B;
    localparam logic [DT_W-1:0] DT_LONG  = 6'h10;

    typedef enum logic [2:0] {
        IDLE,
        HDR1,
        PAYLOAD,
        CRC,
        DRAIN
    } state_t;

    // RAW10 lines are whole 5-byte groups; an empty line is not a line.
    function automatic logic raw10_wc_ok(input logic [WC_W-1:0] wc);
        return (wc != '0) && ((wc % 16'd10) == 16'd0);
    endfunction

endpackage

// File: rtl/csi_rx_packet_ctrl_if.sv
// Payload word counter control bus.
// The FSM drives load/decrement; the counter returns the last flag.
interface csi_rx_packet_ctrl_if;
    import csi_pkg::*;

    logic             load;
    logic             dec;
    logic [REM_W-1:0] load_val;
    logic             last;

    modport master (
        output load,
        output dec,
        output load_val,
        input  last
    );

    modport slave (
        input  load,
        input  dec,
        input  load_val,
        output last
    );

endinterface

// File: rtl/csi_wc_counter.sv
// Remaining payload word counter.
// Loaded with WC/2 at header time, counts down once per payload word.
module csi_wc_counter
    import csi_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    csi_rx_packet_ctrl_if.slave  cnt
);

    logic [REM_W-1:0] r_rem;

    // Load on header, decrement per accepted payload word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem <= '0;
        end else if (cnt.load) begin
            r_rem <= cnt.load_val;
        end else if (cnt.dec) begin
            r_rem <= r_rem - 15'd1;
        end
    end

    assign cnt.last = (r_rem == 15'd1);

endmodule

// File: rtl/csi_rx_packet_ctrl.sv
// CSI-2 packet parser: header decode, frame tracking, RAW10 payload gating.
// Byte pairs arrive as {earlier, later}; one packet per in_valid burst.
module csi_rx_packet_ctrl
    import csi_pkg::*;
#(
    parameter logic [1:0] VC_SEL        = 2'd0,
    parameter int         IN_DATA_WIDTH = 16
) (
    input  logic                     rxbyteclkhs,
    input  logic                     reset_n,
    input  logic [IN_DATA_WIDTH-1:0] data_in,
    input  logic                     in_valid,
    output logic [15:0]              data_out,
    output logic                     frame_valid,
    output logic                     frame_active,
    output logic [15:0]              line_count,
    output logic [15:0]              frame_count,
    output logic                     pkt_err
);

    state_t      r_state, w_state_nxt;
    logic        r_vld_q;
    logic [7:0]  r_di, w_di_nxt;
    logic [7:0]  r_wcl, w_wcl_nxt;
    logic        r_qual, w_qual_nxt;
    logic        r_fv, w_fv_nxt;
    logic        r_fa, w_fa_nxt;
    logic        r_err, w_err_nxt;
    logic [15:0] r_dout, w_dout_nxt;
    logic [15:0] r_lc, w_lc_nxt;
    logic [15:0] r_fc, w_fc_nxt;

    logic [WC_W-1:0] w_wc;
    logic [DT_W-1:0] w_dt;
    logic            w_vc_ok;
    logic            w_raw_hdr;
    logic            w_load;
    logic            w_dec;
    logic            w_last;

    csi_rx_packet_ctrl_if u_cnt_if ();

    assign u_cnt_if.load     = w_load;
    assign u_cnt_if.dec      = w_dec;
    assign u_cnt_if.load_val = w_wc[WC_W-1:1];
    assign w_last            = u_cnt_if.last;

    csi_wc_counter u_cnt (
        .i_clk   (rxbyteclkhs),
        .i_rst_n (reset_n),
        .cnt     (u_cnt_if)
    );

    assign w_wc      = {data_in[15:8], r_wcl};
    assign w_dt      = r_di[DT_W-1:0];
    assign w_vc_ok   = (r_di[7:6] == VC_SEL);
    assign w_raw_hdr = (w_dt == DT_RAW10) && w_vc_ok && r_fv;

    // State and output registers; r_vld_q resets high so a packet
    // already in flight at reset release is skipped until LP.
    always_ff @(posedge rxbyteclkhs or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_vld_q <= 1'b1;
            r_di    <= '0;
            r_wcl   <= '0;
            r_qual  <= 1'b0;
            r_fv    <= 1'b0;
            r_fa    <= 1'b0;
            r_err   <= 1'b0;
            r_dout  <= '0;
            r_lc    <= '0;
            r_fc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vld_q <= in_valid;
            r_di    <= w_di_nxt;
            r_wcl   <= w_wcl_nxt;
            r_qual  <= w_qual_nxt;
            r_fv    <= w_fv_nxt;
            r_fa    <= w_fa_nxt;
            r_err   <= w_err_nxt;
            r_dout  <= w_dout_nxt;
            r_lc    <= w_lc_nxt;
            r_fc    <= w_fc_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_di_nxt    = r_di;
        w_wcl_nxt   = r_wcl;
        w_qual_nxt  = r_qual;
        w_fv_nxt    = r_fv;
        w_lc_nxt    = r_lc;
        w_fc_nxt    = r_fc;
        w_err_nxt   = 1'b0;
        w_fa_nxt    = 1'b0;
        w_dout_nxt  = '0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid && !r_vld_q) begin
                    w_di_nxt    = data_in[15:8];
                    w_wcl_nxt   = data_in[7:0];
                    w_state_nxt = HDR1;
                end
            end
            HDR1: begin
                if (!in_valid) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_dt < DT_LONG) begin
                    w_state_nxt = DRAIN;
                    if (w_vc_ok && w_dt == DT_FS) begin
                        w_fv_nxt = 1'b1;
                        w_lc_nxt = '0;
                    end else if (w_vc_ok && w_dt == DT_FE && r_fv) begin
                        w_fv_nxt = 1'b0;
                        w_fc_nxt = r_fc + 16'd1;
                    end
                end else begin
                    w_qual_nxt = 1'b0;
                    if (w_wc == '0) begin
                        w_state_nxt = CRC;
                    end else begin
                        if (w_raw_hdr) begin
                            if (raw10_wc_ok(w_wc)) w_qual_nxt = 1'b1;
                            else w_err_nxt = 1'b1;
                        end
                        w_load = 1'b1;
                        // A one-byte body has no whole word to skip.
                        if (w_wc[WC_W-1:1] == '0) w_state_nxt = CRC;
                        else w_state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (!in_valid) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_dec    = 1'b1;
                    w_fa_nxt = r_qual;
                    if (r_qual) w_dout_nxt = data_in[15:0];
                    if (w_last) w_state_nxt = CRC;
                end
            end
            CRC: begin
                if (!in_valid) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    if (r_qual && r_lc != 16'hFFFF) w_lc_nxt = r_lc + 16'd1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!in_valid) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign data_out     = r_dout;
    assign frame_valid  = r_fv;
    assign frame_active = r_fa;
    assign line_count   = r_lc;
    assign frame_count  = r_fc;
    assign pkt_err      = r_err;

endmodule

// File: tb/tb_csi_rx_packet_ctrl.sv
// Self-checking bench for csi_rx_packet_ctrl.
// Payload words are queued as driven and popped as data_out appears.
module tb_csi_rx_packet_ctrl;

    logic        clk;
    logic        reset_n;
    logic [15:0] data_in;
    logic        in_valid;
    logic [15:0] data_out;
    logic        frame_valid;
    logic        frame_active;
    logic [15:0] line_count;
    logic [15:0] frame_count;
    logic        pkt_err;

    int n_chk;
    int n_err;
    int err_seen;
    int fa_seen;
    logic [15:0] sb[$];

    csi_rx_packet_ctrl #(
        .VC_SEL        (2'd0),
        .IN_DATA_WIDTH (16)
    ) dut (
        .rxbyteclkhs  (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .in_valid     (in_valid),
        .data_out     (data_out),
        .frame_valid  (frame_valid),
        .frame_active (frame_active),
        .line_count   (line_count),
        .frame_count  (frame_count),
        .pkt_err      (pkt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard on frame_active, zero data otherwise.
    always @(negedge clk) begin
        if (pkt_err === 1'b1) err_seen++;
        if (frame_active === 1'b1) begin
            fa_seen++;
            check("sb_has_word", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("data_out", 32'(data_out), 32'(sb.pop_front()));
        end else begin
            check("dout_zero", 32'(data_out), 32'd0);
        end
    end

    task automatic word(input logic [15:0] d);
        @(posedge clk);
        #1;
        data_in  = d;
        in_valid = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            data_in  = '0;
        end
    endtask

    task automatic pkt(input logic [7:0] di, input logic [15:0] wc,
                       input int npay, input int ntail, input bit q);
        logic [15:0] d;
        word({di, wc[7:0]});
        word({wc[15:8], 8'hA5});
        for (int i = 0; i < npay; i++) begin
            d = 16'($urandom);
            if (q) sb.push_back(d);
            word(d);
        end
        for (int i = 0; i < ntail; i++) word(16'($urandom));
        gap(3);
    endtask

    task automatic chk_outs_zero(input string pfx);
        check({pfx, "_dout"}, 32'(data_out), 32'd0);
        check({pfx, "_fv"}, 32'(frame_valid), 32'd0);
        check({pfx, "_fa"}, 32'(frame_active), 32'd0);
        check({pfx, "_lc"}, 32'(line_count), 32'd0);
        check({pfx, "_fc"}, 32'(frame_count), 32'd0);
        check({pfx, "_err"}, 32'(pkt_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int f0;
        logic [15:0] d;
        n_chk    = 0;
        n_err    = 0;
        err_seen = 0;
        fa_seen  = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_outs_zero("rst");
        reset_n = 1'b1;
        gap(2);

        // FE with no frame open is ignored.
        pkt(8'h01, 16'h0000, 0, 0, 0);
        check("fe_orphan_fc", 32'(frame_count), 32'd0);
        check("fe_orphan_fv", 32'(frame_valid), 32'd0);

        // Basic frame: FS, one RAW10 line, FE.
        pkt(8'h00, 16'h0000, 0, 0, 0);
        check("fs_fv", 32'(frame_valid), 32'd1);
        check("fs_lc", 32'(line_count), 32'd0);
        e0 = err_seen; f0 = fa_seen;
        pkt(8'h2B, 16'd10, 5, 1, 1);
        check("line_fa_cycles", 32'(fa_seen - f0), 32'd5);
        check("line_err", 32'(err_seen - e0), 32'd0);
        check("line_lc", 32'(line_count), 32'd1);
        pkt(8'h01, 16'h0000, 0, 0, 0);
        check("fe_fv", 32'(frame_valid), 32'd0);
        check("fe_fc", 32'(frame_count), 32'd1);
        check("fe_lc", 32'(line_count), 32'd1);

        // Bad word count: error pulse, payload suppressed.
        pkt(8'h00, 16'h0000, 0, 0, 0);
        e0 = err_seen; f0 = fa_seen;
        pkt(8'h2B, 16'd12, 6, 1, 0);
        check("wc12_err", 32'(err_seen - e0), 32'd1);
        check("wc12_fa", 32'(fa_seen - f0), 32'd0);
        check("wc12_lc", 32'(line_count), 32'd0);

        // Truncated after 2 of 5 words, then a normal line.
        e0 = err_seen; f0 = fa_seen;
        pkt(8'h2B, 16'd10, 2, 0, 1);
        check("trunc_err", 32'(err_seen - e0), 32'd1);
        check("trunc_fa", 32'(fa_seen - f0), 32'd2);
        check("trunc_lc", 32'(line_count), 32'd0);
        f0 = fa_seen;
        pkt(8'h2B, 16'd10, 5, 1, 1);
        check("after_trunc_fa", 32'(fa_seen - f0), 32'd5);
        check("after_trunc_lc", 32'(line_count), 32'd1);

        // Other VC and other data type are skipped silently.
        e0 = err_seen; f0 = fa_seen;
        pkt(8'h6B, 16'd10, 5, 1, 0);
        pkt(8'h2A, 16'd10, 5, 1, 0);
        check("skip_err", 32'(err_seen - e0), 32'd0);
        check("skip_fa", 32'(fa_seen - f0), 32'd0);
        check("skip_lc", 32'(line_count), 32'd1);

        // FS while frame open: clear lines, frame stays open.
        pkt(8'h00, 16'h0000, 0, 0, 0);
        check("fsfs_fv", 32'(frame_valid), 32'd1);
        check("fsfs_lc", 32'(line_count), 32'd0);
        check("fsfs_fc", 32'(frame_count), 32'd1);
        pkt(8'h01, 16'h0000, 0, 0, 0);
        check("fe2_fc", 32'(frame_count), 32'd2);

        // Reset in the middle of payload.
        pkt(8'h00, 16'h0000, 0, 0, 0);
        word({8'h2B, 8'd10});
        word({8'h00, 8'hA5});
        for (int i = 0; i < 2; i++) begin
            d = 16'($urandom);
            sb.push_back(d);
            word(d);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk_outs_zero("midrst");
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        e0 = err_seen; f0 = fa_seen;
        for (int i = 0; i < 4; i++) word(16'($urandom));
        gap(3);
        check("rst_tail_fa", 32'(fa_seen - f0), 32'd0);
        check("rst_tail_err", 32'(err_seen - e0), 32'd0);
        check("rst_tail_lc", 32'(line_count), 32'd0);
        check("rst_tail_fv", 32'(frame_valid), 32'd0);
        pkt(8'h00, 16'h0000, 0, 0, 0);
        pkt(8'h2B, 16'd20, 10, 1, 1);
        check("resume_lc", 32'(line_count), 32'd1);
        check("resume_fv", 32'(frame_valid), 32'd1);

        gap(2);
        check("sb_left", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
